// File: rtl/fetch_sequencer.sv
// fetch_sequencer: LEGv8 instruction-fetch controller (PC, IR, stall/branch/halt).
// Optional live fetch counter when FETCH_COUNT_EN is defined; otherwise tied to 0.
module fetch_sequencer #(
  parameter int                  PC_WIDTH  = 64,
  parameter int                  IM_BYTES  = 256,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         HALT_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [31:0]         instr_in,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         instr_out,
  output logic                instr_valid,
  output logic                halted,
  output logic                err,
  output logic [15:0]         fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(IM_BYTES - 4);

  state_t state;
  logic   bad_target;
  logic   is_halt_word;
  logic   deliver;

  assign bad_target   = (branch_target[1:0] != 2'b00)
                      || (branch_target > LAST_PC);
  assign is_halt_word = (instr_in == HALT_WORD);
  assign deliver      = (state == FETCH) && !branch_taken
                      && !stall && !is_halt_word;

  // Fetch FSM: owns PC, instruction register and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_out   <= 32'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          instr_valid <= 1'b0;
          if (run) state <= FETCH;
        end
        FETCH: begin
          instr_valid <= 1'b0;
          if (branch_taken) begin
            if (bad_target) begin
              state  <= HALT;
              halted <= 1'b1;
              err    <= 1'b1;
            end else begin
              pc <= branch_target;
            end
          end else if (stall) begin
            pc <= pc;
          end else if (is_halt_word) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            instr_out   <= instr_in;
            instr_valid <= 1'b1;
            if (pc == LAST_PC) begin
              state  <= HALT;
              halted <= 1'b1;
              err    <= 1'b1;
            end else begin
              pc <= pc + PC_WIDTH'(4);
            end
          end
        end
        HALT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] count_q;

  // Saturating count of delivered instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else if (deliver && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench with a cycle model of the fetch rules.
// Model compared every cycle; literal checks pin the delivered words.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] instr_in;
  logic [63:0] pc;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        halted;
  logic        err;
  logic [15:0] fetch_count;

  logic [31:0] im [64];

  int total = 0;
  int bad   = 0;

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_in     (instr_in),
    .pc           (pc),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .err          (err),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  assign instr_in = im[pc[7:2]];

  // Behavioural model: mode 0=idle 1=fetching 2=halted
  int          m_mode  = 0;
  logic [63:0] m_pc    = 64'd0;
  logic [31:0] m_out   = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_halt  = 1'b0;
  logic        m_err   = 1'b0;
  int          m_count = 0;
  bit          armed   = 1'b0;

  logic [31:0] got [$];

  function automatic int cnt_exp(int n);
`ifdef FETCH_COUNT_EN
    return (n > 65535) ? 65535 : n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] w;
    armed = 1'b1;
    if (reset) begin
      m_mode = 0; m_pc = 64'd0; m_out = 32'd0;
      m_valid = 0; m_halt = 0; m_err = 0; m_count = 0;
    end else if (m_mode == 0) begin
      m_valid = 0;
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      m_valid = 0;
      w = im[m_pc[7:2]];
      if (branch_taken) begin
        if (branch_target % 4 != 0 || branch_target > 64'd252) begin
          m_mode = 2; m_halt = 1; m_err = 1;
        end else begin
          m_pc = branch_target;
        end
      end else if (stall) begin
        m_pc = m_pc;
      end else if (w == 32'd0) begin
        m_mode = 2; m_halt = 1;
      end else begin
        m_out = w; m_valid = 1; m_count++;
        if (m_pc == 64'd252) begin
          m_mode = 2; m_halt = 1; m_err = 1;
        end else begin
          m_pc = m_pc + 64'd4;
        end
      end
    end else begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("pc", pc, m_pc);
      chk("instr_out", 64'(instr_out), 64'(m_out));
      chk("instr_valid", 64'(instr_valid), 64'(m_valid));
      chk("halted", 64'(halted), 64'(m_halt));
      chk("err", 64'(err), 64'(m_err));
      chk("fetch_count", 64'(fetch_count), 64'(cnt_exp(m_count)));
      if (instr_valid) got.push_back(instr_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 64; i++) im[i] = 32'hA000_0000 + 32'(i * 7 + 1);
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got.delete();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 64'd0;
    fill();
    im[0] = 32'hF842_0005;
    im[1] = 32'hF845_0006;
    im[2] = 32'h8B0A_00A1;
    im[3] = 32'h0000_0000;
    tick();
    chk("rst_pc", pc, 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);

    // program ending in a halt word
    restart();
    repeat (6) tick();
    chk("t1_ndeliv", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("t1_w0", 64'(got[0]), 64'hF842_0005);
      chk("t1_w1", 64'(got[1]), 64'hF845_0006);
      chk("t1_w2", 64'(got[2]), 64'h8B0A_00A1);
    end
    chk("t1_pc", pc, 64'd12);
    chk("t1_halted", 64'(halted), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_cnt", 64'(fetch_count), 64'(cnt_exp(3)));

    // stall at pc=4
    fill();
    im[20] = 32'h0;
    restart();
    tick();
    stall = 1'b1;
    tick();
    tick();
    chk("t2_pc", pc, 64'd4);
    chk("t2_valid", 64'(instr_valid), 64'd0);
    chk("t2_out", 64'(instr_out), 64'(im[0]));
    stall = 1'b0;
    tick();
    chk("t2_resume", 64'(instr_out), 64'(im[1]));
    chk("t2_rvalid", 64'(instr_valid), 64'd1);

    // branch at pc=8, then branch with stall
    branch_taken = 1'b1; branch_target = 64'h20;
    tick();
    chk("t3_pc", pc, 64'h20);
    chk("t3_squash", 64'(instr_valid), 64'd0);
    branch_taken = 1'b0;
    tick();
    chk("t3_word", 64'(instr_out), 64'(im[8]));
    chk("t3_valid", 64'(instr_valid), 64'd1);
    branch_taken = 1'b1; stall = 1'b1;
    tick();
    chk("t3s_pc", pc, 64'h20);
    chk("t3s_squash", 64'(instr_valid), 64'd0);
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    chk("t3s_word", 64'(instr_out), 64'(im[8]));

    // misaligned and out-of-range targets
    branch_taken = 1'b1; branch_target = 64'h22;
    tick();
    branch_taken = 1'b0;
    chk("t4a_halted", 64'(halted), 64'd1);
    chk("t4a_err", 64'(err), 64'd1);
    got.delete();
    repeat (4) tick();
    chk("t4a_nodeliv", 64'(got.size()), 64'd0);
    restart();
    branch_taken = 1'b1; branch_target = 64'h100;
    tick();
    branch_taken = 1'b0;
    chk("t4b_halted", 64'(halted), 64'd1);
    chk("t4b_err", 64'(err), 64'd1);
    got.delete();
    repeat (4) tick();
    chk("t4b_nodeliv", 64'(got.size()), 64'd0);

    // run off the end of the IM
    fill();
    restart();
    repeat (70) tick();
    chk("t5_pc", pc, 64'hFC);
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_ndeliv", 64'(got.size()), 64'd64);
    if (got.size() > 0) chk("t5_last", 64'(got[$]), 64'(im[63]));
    chk("t5_cnt", 64'(fetch_count), 64'(cnt_exp(64)));

    // reset in HALT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6h_pc", pc, 64'd0);
    chk("t6h_halted", 64'(halted), 64'd0);
    chk("t6h_err", 64'(err), 64'd0);
    chk("t6h_out", 64'(instr_out), 64'd0);

    // reset mid-fetch at pc=0x10
    restart();
    repeat (4) tick();
    chk("t6f_pc_pre", pc, 64'h10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6f_pc", pc, 64'd0);
    chk("t6f_out", 64'(instr_out), 64'd0);
    chk("t6f_cnt", 64'(fetch_count), 64'd0);

    // run together with reset stays idle
    reset = 1'b1; run = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    repeat (3) tick();
    chk("t6r_pc", pc, 64'd0);
    chk("t6r_valid", 64'(instr_valid), 64'd0);
    chk("t6r_out", 64'(instr_out), 64'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the LEGv8 single-cycle/multicycle datapath. Owns the program counter and sequences the combinational instruction memory: drives `pc` into the IM, captures the returned word into an instruction register, and handles stalls, taken branches, halt detection and out-of-range fetches. Sits between the IM and the decode/control unit; the decode stage consumes `instr_out` when `instr_valid` is high.

## Interface
Parameters:
- `PC_WIDTH`, 64, width of the program counter.
- `IM_BYTES`, 256, byte size of the instruction memory; valid PCs are 0 .. IM_BYTES-4.
- `RESET_PC`, 0, PC value loaded on reset.
- `HALT_WORD`, 32'h0000_0000, instruction encoding that stops fetch.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  start pulse; honoured only in IDLE.
- `stall`  in  1  hold PC and instruction register this cycle.
- `branch_taken`  in  1  redirect fetch to `branch_target`.
- `branch_target`  in  PC_WIDTH  byte address of the redirect.
- `instr_in`  in  32  word returned by the IM for the current `pc` (combinational, same cycle).
- `pc`  out  PC_WIDTH  registered fetch address to the IM.
- `instr_out`  out  32  instruction register.
- `instr_valid`  out  1  `instr_out` holds a new, non-squashed instruction this cycle.
- `halted`  out  1  sequencer in HALT.
- `err`  out  1  halt was caused by a fault (range or alignment).
- `fetch_count`  out  16  number of valid instructions delivered.

## Operation
- States: IDLE, FETCH, HALT. Reset -> IDLE.
- IDLE: `pc` holds RESET_PC; `stall`/`branch_taken` ignored; `run`=1 -> FETCH next cycle.
- FETCH, per-cycle priority: branch_taken > stall > halt-word > sequential.
  - branch_taken: if `branch_target[1:0]`!=0 or `branch_target` > IM_BYTES-4 -> HALT, `err`<=1; else `pc`<=branch_target, `instr_valid`<=0 (current word squashed), `instr_out` held.
  - stall: `pc`, `instr_out` held; `instr_valid`<=0.
  - `instr_in`==HALT_WORD: -> HALT, `instr_valid`<=0, `pc` held, `err` stays 0.
  - sequential: `instr_out`<=instr_in, `instr_valid`<=1, `fetch_count` increments; if `pc`==IM_BYTES-4 -> HALT with `err`<=1 and `pc` held (no wrap), else `pc`<=pc+4.
- HALT: all outputs frozen, `instr_valid`=0, `halted`=1; exits only via reset. `run` ignored.
- PC arithmetic: unsigned PC_WIDTH, +4 never wraps (range check precedes increment).
- `fetch_count` saturates at 16'hFFFF.

## Timing
- Reset values: `pc`=RESET_PC, `instr_out`=0, `instr_valid`=0, `halted`=0, `err`=0, `fetch_count`=0, state IDLE.
- `reset` wins over every other input in the same cycle, including mid-FETCH and in HALT.
- `run` at edge N -> FETCH from edge N; first `instr_valid`=1 after edge N+1 (one-cycle fetch latency: IM word for `pc` at cycle k appears on `instr_out` in cycle k+1).
- `instr_valid` is a one-cycle pulse per delivered instruction; back-to-back unstalled fetch gives one instruction per cycle.
- Branch: `branch_taken` at edge N -> `pc`=target after N; target word valid on `instr_out` after N+1.
- Stall and branch asserted together: branch taken, stall ignored.
- `halted` asserts in the cycle after the halting edge.

## Configuration
- `FETCH_COUNT_EN`: defined -> `fetch_count` is a live saturating 16-bit counter as above. Undefined -> counter not synthesised, `fetch_count` tied to 0; all other behaviour identical.

## Test plan
- Reset, `run` pulse, IM words 0xF8420005, 0xF8450006, 0x8B0A00A1, 0x00000000 at 0,4,8,12 -> three `instr_valid` pulses with those words, `pc` 0->4->8->12, `halted`=1, `err`=0, `fetch_count`=3.
- `stall` high 2 cycles while `pc`=4 -> `pc` stays 4, `instr_valid`=0 for 2 cycles, `instr_out` unchanged, then resumes with word at 4.
- `branch_taken`=1, target=0x20 while `pc`=8 -> next `pc`=0x20, one squash cycle (`instr_valid`=0), then word at 0x20 delivered; repeat with stall also high -> same result.
- Branch target 0x22 -> HALT, `err`=1; target 0x100 -> HALT, `err`=1; no non-halt word delivered after.
- IM filled with non-halt words -> fetch reaches `pc`=0xFC, delivers that word, then `halted`=1, `err`=1, `pc` stays 0xFC.
- `reset` asserted mid-FETCH at `pc`=0x10 and in HALT -> next cycle all outputs at reset values, IDLE; `run`+`reset` same cycle -> stays IDLE.
